// File: rtl/fp_selftest_seq.sv
// Floating-point adder self-test: fetches (a, b, expected) vectors, adds them, compares bitwise.
// Latency: 8 cycles plus 1..MAN_W+1 normalisation cycles per vector.
// Backpressure: none; memory answers one cycle after mem_rd_en, start is ignored while busy.
module fp_selftest_seq #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int NUM_VEC   = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    localparam int W        = 1 + EXP_W + MAN_W,
    localparam int IW       = $clog2(NUM_VEC + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              run_all,
    input  logic [IW-1:0]     vec_sel,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [W-1:0]      mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [IW-1:0]     fail_count,
    output logic [IW-1:0]     first_fail,
    output logic [W-1:0]      last_result,
    output logic              led
);

    localparam int SW = MAN_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_NORM  = 3'd4;
    localparam logic [2:0] S_CMP   = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = 1;
    localparam logic [EXP_W:0]   EXP_ONE1 = 1;
    localparam logic [IW-1:0]    IDX_ONE  = 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_VEC - 1);
    localparam logic [IW-1:0]    NV_IDX   = IW'(NUM_VEC);

    logic [2:0]       state;
    logic [1:0]       fcnt;
    logic [IW-1:0]    idx;
    logic             run_all_q;
    logic [W-1:0]     a_q, b_q, e_q, res;
    logic             x_sgn, eff_sub, n_sgn;
    logic [EXP_W-1:0] x_exp, n_exp;
    logic [SW-1:0]    x_sig, y_sig;
    logic [SW:0]      n_sig;

    // Operand unpacking with zero flush; ordering by {exponent, significand} magnitude.
    logic             a_s, b_s, a_ge;
    logic [EXP_W-1:0] a_exp, b_exp, d_exp;
    logic [SW-1:0]    a_sig, b_sig, sh_sig;
    logic [EXP_W:0]   e_inc;

    assign a_exp  = a_q[W-2 -: EXP_W];
    assign b_exp  = b_q[W-2 -: EXP_W];
    assign a_s    = a_q[W-1] & (a_exp != '0);
    assign b_s    = b_q[W-1] & (b_exp != '0);
    assign a_sig  = (a_exp == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
    assign b_sig  = (b_exp == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
    assign a_ge   = {a_exp, a_sig} >= {b_exp, b_sig};
    assign d_exp  = a_ge ? (a_exp - b_exp) : (b_exp - a_exp);
    assign sh_sig = (int'(d_exp) > SW) ? '0 : ((a_ge ? b_sig : a_sig) >> d_exp);
    assign e_inc  = {1'b0, n_exp} + EXP_ONE1;

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign led       = done && (fail_count == '0);
    assign mem_rd_en = (state == S_FETCH) && (fcnt != 2'd3);
    assign mem_addr  = mem_rd_en ? ADDR_W'(BASE_ADDR + 3 * int'(idx) + int'(fcnt)) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            fcnt        <= '0;
            idx         <= '0;
            run_all_q   <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            e_q         <= '0;
            res         <= '0;
            x_sgn       <= 1'b0;
            eff_sub     <= 1'b0;
            n_sgn       <= 1'b0;
            x_exp       <= '0;
            n_exp       <= '0;
            x_sig       <= '0;
            y_sig       <= '0;
            n_sig       <= '0;
            fail_count  <= '0;
            first_fail  <= NV_IDX;
            last_result <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_FETCH;
                        fcnt       <= '0;
                        idx        <= run_all ? '0 : ((vec_sel > LAST_IDX) ? LAST_IDX : vec_sel);
                        run_all_q  <= run_all;
                        fail_count <= '0;
                        first_fail <= NV_IDX;
                    end
                end
                S_FETCH: begin
                    // Read data trails the strobe by one cycle, so captures lag the addresses.
                    fcnt <= fcnt + 2'd1;
                    if (fcnt == 2'd1) a_q <= mem_rdata;
                    if (fcnt == 2'd2) b_q <= mem_rdata;
                    if (fcnt == 2'd3) begin
                        e_q   <= mem_rdata;
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    x_sgn   <= a_ge ? a_s : b_s;
                    x_exp   <= a_ge ? a_exp : b_exp;
                    x_sig   <= a_ge ? a_sig : b_sig;
                    y_sig   <= sh_sig;
                    eff_sub <= a_s ^ b_s;
                    state   <= S_ADD;
                end
                S_ADD: begin
                    n_sig <= eff_sub ? ({1'b0, x_sig} - {1'b0, y_sig})
                                     : ({1'b0, x_sig} + {1'b0, y_sig});
                    n_exp <= x_exp;
                    n_sgn <= x_sgn;
                    state <= S_NORM;
                end
                S_NORM: begin
                    if (n_sig == '0) begin
                        res   <= '0;
                        state <= S_CMP;
                    end else if (n_sig[SW]) begin
                        if (e_inc >= {1'b0, EXP_ONES})
                            res <= {n_sgn, EXP_ONES, {MAN_W{1'b0}}};
                        else
                            res <= {n_sgn, e_inc[EXP_W-1:0], n_sig[MAN_W:1]};
                        state <= S_CMP;
                    end else if (n_sig[SW-1]) begin
                        if (n_exp == EXP_ONES)
                            res <= {n_sgn, EXP_ONES, {MAN_W{1'b0}}};
                        else
                            res <= {n_sgn, n_exp, n_sig[MAN_W-1:0]};
                        state <= S_CMP;
                    end else begin
                        // One bit per cycle; exponent underflow flushes to +0.
                        n_sig <= n_sig << 1;
                        n_exp <= n_exp - EXP_ONE;
                        if (n_exp == EXP_ONE) begin
                            res   <= '0;
                            state <= S_CMP;
                        end
                    end
                end
                S_CMP: begin
                    last_result <= res;
                    if (res != e_q) begin
                        fail_count <= fail_count + IDX_ONE;
                        if (fail_count == '0) first_fail <= idx;
                    end
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (run_all_q && (idx < LAST_IDX)) begin
                        idx   <= idx + IDX_ONE;
                        fcnt  <= '0;
                        state <= S_FETCH;
                    end else begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
